// File: rtl/rx_bit_timer.sv
// rx_bit_timer
//
// Bit-period timing controller for the serial receive path. While
// enable_timer is high it runs a wrapping clock-tick counter, pulses
// shift_strobe once per bit at a fixed sample point, counts sampled bits,
// and pulses byte_done after every BITS_PER_BYTE strobes.
//
// Optional build macro RX_BIT_TIMER_RESYNC_EN: when defined, a d_edge pulse
// while running reloads the tick counter to 0 so the sample point follows
// the line transitions. When undefined, d_edge is ignored.
//
// Ports:
//   clk           in   system clock, rising edge
//   rst           in   asynchronous, active-high reset
//   enable_timer  in   level: high runs bit timing, low idles and clears
//   d_edge        in   one-cycle pulse marking a detected line transition
//   shift_strobe  out  one-cycle pulse: sample/shift the current bit
//   byte_done     out  one-cycle pulse: a full byte has been sampled
//   bit_index     out  [3:0] bits sampled in the current byte
//   timer_active  out  high while the timer is running

module rx_bit_timer #(
  parameter int CLKS_PER_BIT  = 8,
  parameter int SAMPLE_POINT  = 3,
  parameter int BITS_PER_BYTE = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable_timer,
  input  logic       d_edge,
  output logic       shift_strobe,
  output logic       byte_done,
  output logic [3:0] bit_index,
  output logic       timer_active
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_SMPL = CW'(SAMPLE_POINT);
  localparam logic [3:0]    BIT_LAST = 4'(BITS_PER_BYTE - 1);

  generate
    if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 16) begin : g_bad_cpb
      $error("rx_bit_timer: CLKS_PER_BIT must be in 2..16");
    end
    if (SAMPLE_POINT < 0 || SAMPLE_POINT > CLKS_PER_BIT - 1) begin : g_bad_sp
      $error("rx_bit_timer: SAMPLE_POINT must be in 0..CLKS_PER_BIT-1");
    end
    if (BITS_PER_BYTE < 1 || BITS_PER_BYTE > 16) begin : g_bad_bpb
      $error("rx_bit_timer: BITS_PER_BYTE must be in 1..16");
    end
  endgenerate

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e        state_q;
  logic [CW-1:0] clk_cnt_q;
  logic [3:0]    bit_cnt_q;
  logic          byte_done_q;

  logic strobe;
  logic resync;

  // Moore decode of registered state, so the strobe is glitch-free and
  // never asserted in IDLE.
  assign strobe = (state_q == RUN) && (clk_cnt_q == CNT_SMPL);

`ifdef RX_BIT_TIMER_RESYNC_EN
  assign resync = d_edge;
`else
  logic unused_d_edge;
  assign unused_d_edge = d_edge;
  assign resync        = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      clk_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      byte_done_q <= 1'b0;
    end else begin
      // A strobe on the last bit completes the byte even if the timer is
      // being disabled at this same edge.
      byte_done_q <= strobe && (bit_cnt_q == BIT_LAST);

      if (state_q == IDLE) begin
        clk_cnt_q <= '0;
        bit_cnt_q <= '0;
        if (enable_timer) begin
          state_q <= RUN;
        end
      end else begin
        if (!enable_timer) begin
          state_q   <= IDLE;
          clk_cnt_q <= '0;
          bit_cnt_q <= '0;
        end else begin
          if (resync || (clk_cnt_q == CNT_LAST)) begin
            clk_cnt_q <= '0;
          end else begin
            clk_cnt_q <= clk_cnt_q + 1'b1;
          end
          if (strobe) begin
            bit_cnt_q <= (bit_cnt_q == BIT_LAST) ? 4'd0 : bit_cnt_q + 4'd1;
          end
        end
      end
    end
  end

  assign shift_strobe = strobe;
  assign byte_done    = byte_done_q;
  assign bit_index    = bit_cnt_q;
  assign timer_active = (state_q == RUN);

endmodule

// File: tb/tb_rx_bit_timer.sv
module tb_rx_bit_timer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable_timer = 1'b0;
  logic d_edge = 1'b0;

  // Default configuration
  logic       s0, b0, a0;
  logic [3:0] i0;
  // Minimum period, one bit per byte
  logic       s1, b1, a1;
  logic [3:0] i1;

  always #5 clk = ~clk;

  rx_bit_timer dut0 (
    .clk          (clk),
    .rst          (rst),
    .enable_timer (enable_timer),
    .d_edge       (d_edge),
    .shift_strobe (s0),
    .byte_done    (b0),
    .bit_index    (i0),
    .timer_active (a0)
  );

  rx_bit_timer #(
    .CLKS_PER_BIT  (2),
    .SAMPLE_POINT  (1),
    .BITS_PER_BYTE (1)
  ) dut1 (
    .clk          (clk),
    .rst          (rst),
    .enable_timer (enable_timer),
    .d_edge       (d_edge),
    .shift_strobe (s1),
    .byte_done    (b1),
    .bit_index    (i1),
    .timer_active (a1)
  );

`ifdef RX_BIT_TIMER_RESYNC_EN
  localparam bit RESYNC = 1'b1;
`else
  localparam bit RESYNC = 1'b0;
`endif

  int CPB [2] = '{8, 2};
  int SP  [2] = '{3, 1};
  int BPB [2] = '{8, 1};

  // Reference model: time since alignment and total strobes since enable.
  bit m_run  [2];
  int m_ph   [2];
  int m_nstb [2];
  bit m_bd   [2];

  typedef struct packed {
    logic       stb;
    logic       bd;
    logic [3:0] idx;
    logic       act;
  } obs_t;

  typedef struct packed {
    obs_t c1;
    obs_t c0;
  } pair_t;

  pair_t exp_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
    end
  endtask

  function automatic obs_t model_out(input int c);
    obs_t o;
    o.stb = m_run[c] && ((m_ph[c] % CPB[c]) == SP[c]);
    o.bd  = m_bd[c];
    o.idx = 4'(m_nstb[c] % BPB[c]);
    o.act = m_run[c];
    return o;
  endfunction

  function automatic pair_t cur_exp();
    pair_t p;
    p.c0 = model_out(0);
    p.c1 = model_out(1);
    return p;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_run[c]  = 1'b0;
      m_ph[c]   = 0;
      m_nstb[c] = 0;
      m_bd[c]   = 1'b0;
    end
  endtask

  task automatic model_edge(input int c, input bit r, input bit en, input bit de);
    bit stb;
    if (r) begin
      m_run[c] = 1'b0; m_ph[c] = 0; m_nstb[c] = 0; m_bd[c] = 1'b0;
    end else begin
      stb     = m_run[c] && ((m_ph[c] % CPB[c]) == SP[c]);
      m_bd[c] = stb && (((m_nstb[c] + 1) % BPB[c]) == 0);
      if (!m_run[c]) begin
        m_ph[c] = 0; m_nstb[c] = 0;
        if (en) m_run[c] = 1'b1;
      end else if (!en) begin
        m_run[c] = 1'b0; m_ph[c] = 0; m_nstb[c] = 0;
      end else begin
        if (stb) m_nstb[c]++;
        m_ph[c] = (RESYNC && de) ? 0 : m_ph[c] + 1;
      end
    end
  endtask

  task automatic step(input bit en, input bit de);
    enable_timer = en;
    d_edge       = de;
    @(posedge clk);
    for (int c = 0; c < 2; c++) model_edge(c, rst, en, de);
    exp_q.push_back(cur_exp());
    #1;
  endtask

  // Assert reset between edges and check that outputs clear immediately.
  task automatic async_rst();
    #2;
    rst = 1'b1;
    #1;
    chk("arst_strobe0", s0, 0); chk("arst_bytedone0", b0, 0);
    chk("arst_index0", i0, 0);  chk("arst_active0", a0, 0);
    chk("arst_strobe1", s1, 0); chk("arst_bytedone1", b1, 0);
    chk("arst_index1", i1, 0);  chk("arst_active1", a1, 0);
    model_reset();
    exp_q.delete();
    exp_q.push_back(cur_exp());
  endtask

  // Monitor: every cycle the DUT outputs are compared to the oldest entry.
  initial begin
    pair_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("strobe0",   s0, e.c0.stb);
        chk("bytedone0", b0, e.c0.bd);
        chk("index0",    i0, e.c0.idx);
        chk("active0",   a0, e.c0.act);
        chk("strobe1",   s1, e.c1.stb);
        chk("bytedone1", b1, e.c1.bd);
        chk("index1",    i1, e.c1.idx);
        chk("active1",   a1, e.c1.act);
      end
    end
  end

  initial begin
    model_reset();

    // Reset held, then idle
    repeat (3) step(1'b0, 1'b0);
    rst = 1'b0;
    repeat (2) step(1'b0, 1'b0);

    // Continuous run across a full byte and beyond
    repeat (71) step(1'b1, 1'b0);

    // Idle, then enable for 21 cycles, drop, idle
    repeat (10) step(1'b0, 1'b0);
    repeat (21) step(1'b1, 1'b0);
    repeat (6) step(1'b0, 1'b0);

    // Enable dropped at the edge ending the 8th strobe cycle
    repeat (60) step(1'b1, 1'b0);
    repeat (5) step(1'b0, 1'b0);

    // Transition pulse while tick counter reads 6
    repeat (7) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    repeat (12) step(1'b1, 1'b0);
    repeat (3) step(1'b0, 1'b0);

    // Asynchronous reset mid-byte, then 50 idle cycles
    repeat (30) step(1'b1, 1'b0);
    async_rst();
    step(1'b1, 1'b0);
    rst = 1'b0;
    repeat (50) step(1'b0, 1'b0);

    // Randomized traffic
    repeat (600) begin
      if ($urandom_range(0, 199) == 0) begin
        async_rst();
        step(1'b0, 1'b0);
        rst = 1'b0;
      end else begin
        step($urandom_range(0, 63) != 0, $urandom_range(0, 7) == 0);
      end
    end

    repeat (2) step(1'b0, 1'b0);
    @(negedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
